frame_buffer_write_arbiter: RTL and testbench



---
 rtl/frame_buffer_write_arbiter.sv | 110 +++++++++++
 tb/tb_frame_buffer_write_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_buffer_write_arbiter.sv
// frame_buffer_write_arbiter: round-robin arbiter merging fill/line/symbol pixel writes
// into one registered frame buffer write port, with burst limiting and swap stall.
module frame_buffer_write_arbiter #(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480,
   parameter int MAX_BURST = 64,
   localparam int ADDR_WIDTH = $clog2(HOR_ACTIVE_PIXELS * VER_ACTIVE_PIXELS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic                  req0_data,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic                  req1_data,
   output logic                  req1_ready,
   input  logic                  req2_valid,
   input  logic [ADDR_WIDTH-1:0] req2_addr,
   input  logic                  req2_data,
   output logic                  req2_ready,
   input  logic                  swap,
   output logic                  write_enable,
   output logic [ADDR_WIDTH-1:0] write_addr,
   output logic                  write_data,
   output logic                  busy
);
   localparam int CW = $clog2(MAX_BURST + 1);
   typedef enum logic [1:0] {NONE, G0, G1, G2} grant_t;
   grant_t grant_q, grant_d;
   logic [1:0] last_q, last_d, owner, base, c1, c2, pick;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] valid, gnt_oh, ready;
   logic own_valid, other_valid, accept, any_valid;
   logic we_q, data_q, sel_data;
   logic [ADDR_WIDTH-1:0] addr_q, sel_addr;

   function automatic logic [1:0] next3(input logic [1:0] x);
      return (x == 2'd2) ? 2'd0 : x + 2'd1;
   endfunction

   function automatic logic bit3(input logic [2:0] v, input logic [1:0] i);
      return (i == 2'd0) ? v[0] : (i == 2'd1) ? v[1] : v[2];
   endfunction

   assign valid = {req2_valid, req1_valid, req0_valid};
   assign gnt_oh = {grant_q == G2, grant_q == G1, grant_q == G0};
   assign ready = gnt_oh & {3{~swap & ~rst}};
   assign owner = (grant_q == G1) ? 2'd1 : (grant_q == G2) ? 2'd2 : 2'd0;
   assign own_valid = |(gnt_oh & valid);
   assign other_valid = |(valid & ~gnt_oh);
   assign any_valid = |valid;
   assign accept = |(ready & valid);
   // Round-robin scan starts after the last owner, or after the departing owner.
   assign base = (grant_q == NONE) ? last_q : owner;
   assign c1 = next3(base);
   assign c2 = next3(c1);
   assign pick = bit3(valid, c1) ? c1 : bit3(valid, c2) ? c2 : base;
   assign sel_addr = (owner == 2'd1) ? req1_addr : (owner == 2'd2) ? req2_addr : req0_addr;
   assign sel_data = (owner == 2'd1) ? req1_data : (owner == 2'd2) ? req2_data : req0_data;

   always_comb begin
      grant_d = grant_q;
      last_d = last_q;
      cnt_d = cnt_q;
      if (!swap) begin
         if (!own_valid) begin
            grant_d = any_valid ? grant_t'(pick + 2'd1) : NONE;
            last_d = (grant_q == NONE) ? last_q : owner;
            cnt_d = '0;
         end else if (cnt_q == CW'(MAX_BURST - 1)) begin
            // Burst exhausted: yield through NONE so the change costs one bubble.
            cnt_d = '0;
            grant_d = other_valid ? NONE : grant_q;
            last_d = other_valid ? owner : last_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant_q <= NONE;
         last_q <= 2'd2;
         cnt_q <= '0;
         we_q <= 1'b0;
         addr_q <= '0;
         data_q <= 1'b0;
      end else begin
         grant_q <= grant_d;
         last_q <= last_d;
         cnt_q <= cnt_d;
         we_q <= accept;
         if (accept) begin
            addr_q <= sel_addr;
            data_q <= sel_data;
         end
      end
   end

   assign req0_ready = ready[0];
   assign req1_ready = ready[1];
   assign req2_ready = ready[2];
   assign write_enable = we_q;
   assign write_addr = addr_q;
   assign write_data = data_q;
   assign busy = any_valid | (we_q & ~rst);
endmodule

// File: tb/tb_frame_buffer_write_arbiter.sv
// tb_frame_buffer_write_arbiter: vector table, directed corner sequences and a
// randomized run checked against a requester-level arbitration model.
module tb_frame_buffer_write_arbiter;
   localparam int HP = 16;
   localparam int VP = 16;
   localparam int MB = 4;
   localparam int AW = $clog2(HP * VP);

   typedef struct {
      logic r, s;
      logic [2:0] v, rdy;
      logic we;
      logic [AW-1:0] addr;
      logic d, busy;
   } vec_t;

   typedef struct {
      logic [AW-1:0] a;
      logic d;
   } beat_t;

   logic clk = 1'b0;
   logic rst, swap;
   logic [2:0] vld, rdy;
   logic [AW-1:0] adr [3];
   logic dat [3];
   logic r0, r1, r2, write_enable, write_data, busy;
   logic [AW-1:0] write_addr;

   beat_t q [3][$];
   int acc_log[$];
   int wr_log[$];
   int n_chk = 0, n_fail = 0, gap_pct = 0;
   int m_own, m_last, m_cnt;
   logic exp_we, exp_data;
   logic [AW-1:0] exp_addr;
   vec_t tbl [14];

   always #5 clk = ~clk;
   assign rdy = {r2, r1, r0};

   frame_buffer_write_arbiter #(.HOR_ACTIVE_PIXELS(HP), .VER_ACTIVE_PIXELS(VP), .MAX_BURST(MB)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(vld[0]), .req0_addr(adr[0]), .req0_data(dat[0]), .req0_ready(r0),
      .req1_valid(vld[1]), .req1_addr(adr[1]), .req1_data(dat[1]), .req1_ready(r1),
      .req2_valid(vld[2]), .req2_addr(adr[2]), .req2_data(dat[2]), .req2_ready(r2),
      .swap(swap), .write_enable(write_enable), .write_addr(write_addr),
      .write_data(write_data), .busy(busy)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_seq(input string nm, input int e[$]);
      int bad = -1;
      for (int i = 0; i < e.size(); i++)
         if (bad < 0 && (i >= acc_log.size() || acc_log[i] != e[i])) bad = i;
      n_chk++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: accept owner at cycle %0d got %0d expected %0d", nm, bad,
                  (bad < acc_log.size()) ? acc_log[bad] : -9, e[bad]);
      end
   endtask

   task automatic chk_wr(input string nm, input int first, input int n);
      int bad = (wr_log.size() != n) ? n : -1;
      for (int i = 0; i < n && i < wr_log.size(); i++)
         if (bad < 0 && wr_log[i] != first + i) bad = i;
      n_chk++;
      if (bad >= 0) begin
         n_fail++;
         $display("FAIL %s: write address stream wrong at index %0d (got %0d writes, expected %0d)",
                  nm, bad, wr_log.size(), n);
      end
   endtask

   task automatic hard_reset();
      rst = 1'b1;
      swap = 1'b0;
      vld = 3'b000;
      for (int n = 0; n < 3; n++) begin
         q[n].delete();
         adr[n] = '0;
         dat[n] = 1'b0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      m_own = -1;
      m_last = 2;
      m_cnt = 0;
      exp_we = 1'b0;
      exp_addr = '0;
      exp_data = 1'b0;
      #1;
      chk("reset_we", 32'(write_enable), 0);
      chk("reset_addr", 32'(write_addr), 0);
      chk("reset_ready", 32'(rdy), 0);
      acc_log.delete();
      wr_log.delete();
   endtask

   // One cycle: present queued beats, check against the model, then advance.
   task automatic step(input logic r, input logic s);
      logic [2:0] m_rdy, m_acc, d_acc;
      int base, nxt;
      for (int n = 0; n < 3; n++) begin
         if (q[n].size() == 0) vld[n] = 1'b0;
         else if (!vld[n]) vld[n] = ($urandom_range(99) >= gap_pct);
         if (vld[n]) begin
            adr[n] = q[n][0].a;
            dat[n] = q[n][0].d;
         end
      end
      rst = r;
      swap = s;
      #1;
      m_rdy = 3'b000;
      if (!r && !s && m_own >= 0) m_rdy[m_own] = 1'b1;
      m_acc = m_rdy & vld;
      chk("ready", 32'(rdy), 32'(m_rdy));
      chk("write_enable", 32'(write_enable), 32'(exp_we));
      chk("write_addr", 32'(write_addr), 32'(exp_addr));
      chk("write_data", 32'(write_data), 32'(exp_data));
      chk("busy", 32'(busy), 32'((|vld) || (exp_we && !r)));
      if (write_enable) wr_log.push_back(int'(write_addr));
      acc_log.push_back(m_acc[0] ? 0 : m_acc[1] ? 1 : m_acc[2] ? 2 : -1);
      if (r) begin
         exp_we = 1'b0;
         exp_addr = '0;
         exp_data = 1'b0;
      end else begin
         exp_we = |m_acc;
         for (int n = 0; n < 3; n++)
            if (m_acc[n]) begin
               exp_addr = adr[n];
               exp_data = dat[n];
            end
      end
      if (r) begin
         m_own = -1;
         m_last = 2;
         m_cnt = 0;
      end else if (!s) begin
         if (m_own < 0 || !vld[m_own]) begin
            base = (m_own < 0) ? m_last : m_own;
            if (m_own >= 0) m_last = m_own;
            nxt = -1;
            for (int k = 3; k >= 1; k--)
               if (vld[(base + k) % 3]) nxt = (base + k) % 3;
            m_own = nxt;
            m_cnt = 0;
         end else begin
            m_cnt++;
            if (m_cnt == MB) begin
               m_cnt = 0;
               if ((vld & ~(3'b001 << m_own)) != 3'b000) begin
                  m_last = m_own;
                  m_own = -1;
               end
            end
         end
      end
      d_acc = rdy & vld;
      @(posedge clk);
      @(negedge clk);
      for (int n = 0; n < 3; n++)
         if (d_acc[n]) begin
            void'(q[n].pop_front());
            vld[n] = 1'b0;
         end
   endtask

   task automatic push(input int n, input int a, input logic d);
      beat_t b;
      b.a = AW'(a);
      b.d = d;
      q[n].push_back(b);
   endtask

   initial begin
      int e[$];
      tbl[0]  = '{1, 0, 3'b000, 3'b000, 0, 0,   0, 0};
      tbl[1]  = '{0, 0, 3'b010, 3'b000, 0, 0,   0, 1};
      tbl[2]  = '{0, 0, 3'b010, 3'b010, 0, 0,   0, 1};
      tbl[3]  = '{0, 0, 3'b000, 3'b010, 1, 100, 1, 1};
      tbl[4]  = '{0, 0, 3'b000, 3'b000, 0, 100, 1, 0};
      tbl[5]  = '{1, 0, 3'b000, 3'b000, 0, 100, 1, 0};
      tbl[6]  = '{0, 0, 3'b111, 3'b000, 0, 0,   0, 1};
      tbl[7]  = '{0, 0, 3'b111, 3'b001, 0, 0,   0, 1};
      tbl[8]  = '{0, 0, 3'b110, 3'b001, 1, 10,  1, 1};
      tbl[9]  = '{0, 0, 3'b110, 3'b010, 0, 10,  1, 1};
      tbl[10] = '{0, 0, 3'b100, 3'b010, 1, 100, 1, 1};
      tbl[11] = '{0, 0, 3'b100, 3'b100, 0, 100, 1, 1};
      tbl[12] = '{0, 0, 3'b000, 3'b100, 1, 200, 0, 1};
      tbl[13] = '{0, 0, 3'b000, 3'b000, 0, 200, 0, 0};
      rst = 1'b1;
      swap = 1'b0;
      vld = 3'b000;
      hard_reset();
      adr[0] = 8'd10;  dat[0] = 1'b1;
      adr[1] = 8'd100; dat[1] = 1'b1;
      adr[2] = 8'd200; dat[2] = 1'b0;
      for (int i = 0; i < 14; i++) begin
         rst = tbl[i].r;
         swap = tbl[i].s;
         vld = tbl[i].v;
         #1;
         chk($sformatf("tbl%0d_ready", i), 32'(rdy), 32'(tbl[i].rdy));
         chk($sformatf("tbl%0d_we", i), 32'(write_enable), 32'(tbl[i].we));
         chk($sformatf("tbl%0d_addr", i), 32'(write_addr), 32'(tbl[i].addr));
         chk($sformatf("tbl%0d_data", i), 32'(write_data), 32'(tbl[i].d));
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
         @(posedge clk);
         @(negedge clk);
      end

      hard_reset();
      for (int i = 0; i < 10; i++) push(0, i, 1'(i));
      push(2, 50, 1'b1);
      repeat (16) step(1'b0, 1'b0);
      e = '{-1, 0, 0, 0, 0, -1, 2, -1, 0, 0};
      chk_seq("burst_rotate", e);
      chk("burst_rotate_drain", 32'(q[0].size()), 0);

      hard_reset();
      for (int i = 0; i < 2 * MB + 3; i++) push(0, i, 1'(i));
      repeat (14) step(1'b0, 1'b0);
      e = '{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
      chk_seq("burst_wrap", e);
      chk_wr("burst_wrap_wr", 0, 2 * MB + 3);

      hard_reset();
      for (int i = 0; i < 6; i++) push(1, 40 + i, 1'(i));
      for (int c = 0; c < 10; c++) step(1'b0, c == 3);
      e = '{-1, 1, 1, -1, 1, 1, 1, 1, -1};
      chk_seq("swap_stall", e);
      chk_wr("swap_stall_wr", 40, 6);

      hard_reset();
      for (int i = 0; i < 6; i++) push(2, 60 + i, 1'b1);
      repeat (3) step(1'b0, 1'b0);
      push(0, 5, 1'b1);
      step(1'b1, 1'b0);
      chk("rst_abort_addr", 32'(write_addr), 0);
      repeat (10) step(1'b0, 1'b0);
      e = '{-1, 2, 2, -1, -1, 0, -1, 2};
      chk_seq("rst_abort", e);

      hard_reset();
      gap_pct = 30;
      for (int n = 0; n < 3; n++)
         for (int i = 0; i < 40; i++) push(n, int'($urandom_range(HP * VP - 1)), 1'($urandom));
      for (int c = 0; c < 3000 && (q[0].size() + q[1].size() + q[2].size()) != 0; c++)
         step($urandom_range(99) < 2, $urandom_range(99) < 10);
      step(1'b0, 1'b0);
      for (int n = 0; n < 3; n++) chk($sformatf("random_drain%0d", n), 32'(q[n].size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
